// File: rtl/i2c_pkg.sv
// Shared I2C constants and the arbiter FSM state encoding used by the
// requester-sharing logic in front of the I2C core.
package i2c_pkg;

   localparam int I2C_ADDR_W      = 7;
   localparam int I2C_DATA_W      = 8;
   localparam int I2C_TIMEOUT_DEF = 65535;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RESP      = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping around; returns one-hot grant plus its binary index.
module rr_arb #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   int unsigned j;

   always_comb begin
      any = 1'b0;
      gnt = '0;
      idx = '0;
      j   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = (32'(ptr) + i) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C core among NREQ requesters: round-robin pick, latch the
// winner's command, issue it, wait for done/timeout, return the response.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = I2C_TIMEOUT_DEF,
   parameter int CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req,
   input  logic [I2C_ADDR_W*NREQ-1:0]   req_addr,
   input  logic [NREQ-1:0]              req_r_w,
   input  logic [I2C_DATA_W*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]              gnt,
   output logic [NREQ-1:0]              rsp_valid,
   output logic [I2C_DATA_W-1:0]        rsp_rdata,
   output logic                         rsp_err,
   output logic                         rsp_timeout,
   output logic                         i2c_new_dat,
   output logic [I2C_ADDR_W-1:0]        i2c_addr,
   output logic                         i2c_r_w,
   output logic [I2C_DATA_W-1:0]        i2c_dat_in,
   input  logic [I2C_DATA_W-1:0]        i2c_dat_out,
   input  logic                         i2c_busy,
   input  logic                         i2c_ack_err,
   input  logic                         i2c_done
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t              state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        sel_q, sel_d;
   logic [NREQ-1:0]         gnt_q, gnt_d;
   logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
   logic [I2C_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic                    new_dat_q, new_dat_d;
   logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
   logic                    r_w_q, r_w_d;
   logic [I2C_DATA_W-1:0]   dat_in_q, dat_in_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_flag_q, err_flag_d;

   logic                    arb_any;
   logic [NREQ-1:0]         arb_gnt;
   logic [IDX_W-1:0]        arb_idx;

   rr_arb #(
      .N     (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_arb (
      .req (req),
      .ptr (rr_ptr_q),
      .any (arb_any),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      sel_d         = sel_q;
      gnt_d         = gnt_q;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      new_dat_d     = 1'b0;
      addr_d        = addr_q;
      r_w_d         = r_w_q;
      dat_in_d      = dat_in_q;
      cnt_d         = cnt_q;
      err_flag_d    = err_flag_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               sel_d    = arb_idx;
               gnt_d    = arb_gnt;
               addr_d   = req_addr[int'(arb_idx)*I2C_ADDR_W +: I2C_ADDR_W];
               r_w_d    = req_r_w[arb_idx];
               dat_in_d = req_wdata[int'(arb_idx)*I2C_DATA_W +: I2C_DATA_W];
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!i2c_busy) begin
               new_dat_d  = 1'b1;
               cnt_d      = '0;
               err_flag_d = 1'b0;
               state_d    = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            cnt_d      = cnt_q + 1'b1;
            err_flag_d = err_flag_q | i2c_ack_err;
            // Response is registered on entry to RESP so rsp_valid and the
            // gnt drop coincide with the RESP cycle; done beats timeout.
            if (i2c_done) begin
               rsp_rdata_d   = i2c_dat_out;
               rsp_err_d     = err_flag_q | i2c_ack_err;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = gnt_q;
               gnt_d         = '0;
               state_d       = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = gnt_q;
               gnt_d         = '0;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            rr_ptr_d = (sel_q == IDX_W'(NREQ - 1)) ? '0 : sel_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         sel_q         <= '0;
         gnt_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         new_dat_q     <= 1'b0;
         addr_q        <= '0;
         r_w_q         <= 1'b0;
         dat_in_q      <= '0;
         cnt_q         <= '0;
         err_flag_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         sel_q         <= sel_d;
         gnt_q         <= gnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         new_dat_q     <= new_dat_d;
         addr_q        <= addr_d;
         r_w_q         <= r_w_d;
         dat_in_q      <= dat_in_d;
         cnt_q         <= cnt_d;
         err_flag_q    <= err_flag_d;
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign i2c_new_dat = new_dat_q;
   assign i2c_addr    = addr_q;
   assign i2c_r_w     = r_w_q;
   assign i2c_dat_in  = dat_in_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: grant order and responses are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_i2c_req_arbiter;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [7*NREQ-1:0] req_addr = '0;
   logic [NREQ-1:0]   req_r_w = '0;
   logic [8*NREQ-1:0] req_wdata = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              i2c_new_dat;
   logic [6:0]        i2c_addr;
   logic              i2c_r_w;
   logic [7:0]        i2c_dat_in;
   logic [7:0]        i2c_dat_out = '0;
   logic              i2c_busy = 1'b0;
   logic              i2c_ack_err = 1'b0;
   logic              i2c_done = 1'b0;

   i2c_req_arbiter #(
      .NREQ        (NREQ),
      .TIMEOUT_CYC (20),
      .CNT_W       (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_addr    (req_addr),
      .req_r_w     (req_r_w),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .i2c_new_dat (i2c_new_dat),
      .i2c_addr    (i2c_addr),
      .i2c_r_w     (i2c_r_w),
      .i2c_dat_in  (i2c_dat_in),
      .i2c_dat_out (i2c_dat_out),
      .i2c_busy    (i2c_busy),
      .i2c_ack_err (i2c_ack_err),
      .i2c_done    (i2c_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned idx;
      logic [7:0]  rd;
      logic        err;
      logic        to;
      int unsigned lat;
   } exp_t;

   exp_t        sb[$];
   int unsigned gq[$];
   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int unsigned i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Monitor: grant order, command integrity at new_dat, response contents.
   logic [NREQ-1:0] gnt_prev = '0;
   logic [6:0]      prev_addr = '0;
   int unsigned     cyc = 0;
   int unsigned     nd_cyc = 0;
   int unsigned     nd_cnt = 0;
   int unsigned     nd_total = 0;
   int unsigned     gi;
   int unsigned     ge;
   exp_t            ex;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         gnt_prev = '0;
      end else begin
         if (gnt != '0) chk("gnt_onehot", 64'($countones(gnt)), 1);
         if (gnt != '0 && gnt_prev == '0) begin
            nd_cnt = 0;
            if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
            else begin
               ge = gq.pop_front();
               chk("gnt_order", gnt, onehot(ge));
            end
         end
         if (i2c_new_dat) begin
            nd_cnt++;
            nd_total++;
            nd_cyc = cyc;
            gi = 0;
            for (int unsigned i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
            chk("nd_gnt", gnt != '0, 1);
            chk("nd_addr", i2c_addr, req_addr[gi*7 +: 7]);
            chk("nd_dat_in", i2c_dat_in, req_wdata[gi*8 +: 8]);
            chk("nd_r_w", i2c_r_w, req_r_w[gi]);
            chk("addr_setup", prev_addr, i2c_addr);
         end
         if (rsp_valid != '0) begin
            if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
               ex = sb.pop_front();
               chk("rsp_valid", rsp_valid, onehot(ex.idx));
               chk("rsp_rdata", rsp_rdata, ex.rd);
               chk("rsp_err", rsp_err, ex.err);
               chk("rsp_timeout", rsp_timeout, ex.to);
               chk("rsp_gnt_low", gnt, 0);
               chk("nd_per_gnt", nd_cnt, 1);
               if (ex.lat != 0) chk("to_latency", cyc - nd_cyc, ex.lat);
            end
         end
         gnt_prev = gnt;
      end
      prev_addr = i2c_addr;
   end

   task automatic set_req(input int unsigned i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      req_addr[i*7 +: 7]  = a;
      req_r_w[i]          = rw;
      req_wdata[i*8 +: 8] = wd;
      req[i]              = 1'b1;
   endtask

   task automatic push(input int unsigned i, input logic [7:0] rd, input logic err,
                       input logic to, input int unsigned lat);
      exp_t e;
      e.idx = i; e.rd = rd; e.err = err; e.to = to; e.lat = lat;
      sb.push_back(e);
   endtask

   // Core model: wait for new_dat, then return done after lat cycles.
   task automatic serve(input logic [7:0] rd, input int unsigned lat, input int unsigned err_at,
                        input logic err_done, input logic give_done);
      int unsigned n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!i2c_new_dat && n < 60);
      if (!i2c_new_dat) begin
         chk("new_dat_wait", 0, 1);
         return;
      end
      i2c_dat_out = rd;
      if (!give_done) return;
      for (int unsigned k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         i2c_ack_err = (k == err_at) || (k == lat && err_done);
         i2c_done    = (k == lat);
      end
      @(posedge clk); #1;
      i2c_ack_err = 1'b0;
      i2c_done    = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, i2c_new_dat,
                i2c_addr, i2c_r_w, i2c_dat_in}, 0);
   endtask

   initial begin
      int unsigned n;
      logic [7:0] crd [5];
      crd[0] = 8'h10; crd[1] = 8'h21; crd[2] = 8'h32; crd[3] = 8'h43; crd[4] = 8'h54;

      repeat (3) @(negedge clk);
      chk_all_zero("reset_outputs");
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention: all four held, rotation from pointer 0
      @(posedge clk); #1;
      set_req(0, 7'h10, 1'b0, 8'h01);
      set_req(1, 7'h11, 1'b1, 8'h02);
      set_req(2, 7'h12, 1'b0, 8'h03);
      set_req(3, 7'h13, 1'b1, 8'h04);
      gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
      push(0, crd[0], 0, 0, 0); push(1, crd[1], 0, 0, 0); push(2, crd[2], 0, 0, 0);
      push(3, crd[3], 0, 0, 0); push(0, crd[4], 0, 0, 0);
      for (int k = 0; k < 5; k++) serve(crd[k], 2, 0, 1'b0, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Single write from requester 1
      @(posedge clk); #1;
      set_req(1, 7'h50, 1'b0, 8'hA5);
      gq.push_back(1);
      push(1, 8'h77, 0, 0, 0);
      @(negedge clk);
      chk("gnt_before", gnt, 0);
      @(negedge clk);
      chk("gnt_next_cycle", gnt, 4'b0010);
      serve(8'h77, 3, 0, 1'b0, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Read from requester 0
      @(posedge clk); #1;
      set_req(0, 7'h21, 1'b1, 8'h00);
      gq.push_back(0);
      push(0, 8'h3C, 0, 0, 0);
      serve(8'h3C, 3, 0, 1'b0, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Ack error mid-transaction
      @(posedge clk); #1;
      set_req(2, 7'h2B, 1'b0, 8'h9C);
      gq.push_back(2);
      push(2, 8'h11, 1, 0, 0);
      serve(8'h11, 4, 2, 1'b0, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Ack error in the done cycle
      @(posedge clk); #1;
      set_req(3, 7'h4D, 1'b1, 8'h00);
      gq.push_back(3);
      push(3, 8'h22, 1, 0, 0);
      serve(8'h22, 3, 0, 1'b1, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Timeout: done never arrives
      @(posedge clk); #1;
      set_req(1, 7'h3A, 1'b1, 8'h00);
      gq.push_back(1);
      push(1, 8'h00, 1, 1, 20);
      serve(8'hEE, 0, 0, 1'b0, 1'b0);
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_rsp_seen", sb.size(), 0);
      req = '0;
      i2c_dat_out = '0;
      repeat (3) @(posedge clk);
      chk("timeout_gnt_idle", gnt, 0);

      // Busy hold-off
      @(posedge clk); #1;
      i2c_busy = 1'b1;
      n = nd_total;
      set_req(2, 7'h55, 1'b0, 8'h5A);
      gq.push_back(2);
      push(2, 8'h99, 0, 0, 0);
      repeat (6) @(negedge clk);
      chk("busy_no_new_dat", nd_total - n, 0);
      chk("busy_gnt_held", gnt, 4'b0100);
      @(posedge clk); #1;
      i2c_busy = 1'b0;
      serve(8'h99, 2, 0, 1'b0, 1'b1);
      req = '0;
      repeat (3) @(posedge clk);

      // Reset during WAIT_DONE, then pointer restarts at 0
      @(posedge clk); #1;
      set_req(3, 7'h66, 1'b1, 8'h00);
      gq.push_back(3);
      serve(8'h44, 0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      req = '0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midtx_reset_outputs");
      @(posedge clk); #1;
      rst = 1'b0;
      i2c_dat_out = '0;
      repeat (4) @(negedge clk);
      chk("no_rsp_after_reset", sb.size(), 0);
      @(posedge clk); #1;
      set_req(1, 7'h12, 1'b0, 8'hC3);
      set_req(3, 7'h34, 1'b0, 8'h3C);
      gq.push_back(1);
      push(1, 8'h5E, 0, 0, 0);
      serve(8'h5E, 2, 0, 1'b0, 1'b1);
      req = '0;

      repeat (6) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("gq_empty", gq.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single I2C master/slave core (i2ctop) between NREQ independent requesters.
- Round-robin arbitration; latches the winner's address, direction and write byte, then drives the core's new_dat/addr/r_w/dat_in.
- Waits for completion, then returns read data and error status to the winning requester.
- Sits between the protocol-select/host logic and the I2C core; the only block that drives the core's command inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, max clk cycles from new_dat pulse to core done before the transaction is aborted.
- CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester transaction request; held until own rsp_valid.
- req_addr  in  7*NREQ  7-bit target address per requester; slice i = bits [7i+6:7i].
- req_r_w  in  NREQ  1 = read, 0 = write.
- req_wdata  in  8*NREQ  write byte per requester; slice i = bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant; high from issue until response.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  8  read byte; valid with rsp_valid.
- rsp_err  out  1  ack error or timeout; valid with rsp_valid.
- rsp_timeout  out  1  transaction aborted by timeout; valid with rsp_valid.
- i2c_new_dat  out  1  one-cycle start pulse to core.
- i2c_addr  out  7  latched address to core.
- i2c_r_w  out  1  latched direction to core.
- i2c_dat_in  out  8  latched write byte to core.
- i2c_dat_out  in  8  read byte from core.
- i2c_busy  in  1  core busy.
- i2c_ack_err  in  1  core ack error (master|slave).
- i2c_done  in  1  core done pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0, error flag 0. Reset mid-transaction abandons it with no rsp_valid. The core is not reset by this block.
- FSM states are IDLE, ISSUE, WAIT_DONE and RESP. Transitions are listed below.
- IDLE: if any req bit is set, select the first set bit searching from rr_ptr upward with wrap. Latch addr, r_w and wdata into the i2c_* outputs. Next cycle: gnt[sel]=1, go to ISSUE. Requests arriving in any other state wait.
- ISSUE: if i2c_busy=0, assert i2c_new_dat for exactly this cycle, clear counter and error flag, go to WAIT_DONE. If busy, stay in ISSUE and keep new_dat low.
- Latency: req seen at cycle N gives gnt at N+1 and i2c_new_dat at N+2 at earliest. i2c_addr/r_w/dat_in are stable at least one cycle before new_dat and for the whole transaction.
- WAIT_DONE:
  - Counter increments each cycle.
  - i2c_ack_err high in any cycle sets the sticky error flag.
  - On i2c_done=1: capture i2c_dat_out into rsp_rdata; rsp_err = flag | i2c_ack_err (same-cycle err counts); go to RESP.
  - If done is not seen and counter == TIMEOUT_CYC-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid[sel]=1 for one cycle, gnt cleared in the same cycle.
  - rr_ptr = (sel+1) mod NREQ.
  - Return to IDLE.
  - rsp_rdata/rsp_err/rsp_timeout hold until the next RESP.
- At least one IDLE cycle occurs between transactions. Back-to-back requests from all requesters are served in strict rotation, with no starvation.
- If req[sel] drops mid-transaction, the transaction completes and rsp_valid still pulses. A requester must sample only its own rsp_valid.
- Write transactions return rsp_rdata = i2c_dat_out as-is; requesters ignore it.

Decomposition:
- Shared package i2c_pkg: state encoding, I2C_ADDR_W=7, I2C_DATA_W=8, default TIMEOUT_CYC.
- One sub-module, rr_arb: combinational round-robin selector (req vector + ptr -> one-hot grant + index). It is reusable by the SPI/UART sharers.

Test Plan:
- Single write: req[1]=1, addr=7'h50, r_w=0, wdata=8'hA5 -> gnt=4'b0010 next cycle; i2c_new_dat one pulse with i2c_addr=50, i2c_dat_in=A5; after i2c_done, rsp_valid=4'b0010, rsp_err=0.
- Read: req[0], r_w=1, core returns dat_out=8'h3C with done -> rsp_rdata=3C, rsp_valid[0] one cycle, gnt[0] low the same cycle.
- Contention: req=4'b1111 held continuously -> grant order 0,1,2,3,0; exactly one new_dat per grant; never two gnt bits set.
- Ack error: i2c_ack_err pulses mid-transaction, then done -> rsp_err=1, rsp_timeout=0. Second case: err and done in the same cycle -> rsp_err=1.
- Timeout: TIMEOUT_CYC=20, done never asserted -> rsp_valid exactly 20 cycles after new_dat, rsp_err=1, rsp_timeout=1, arbiter back to IDLE.
- Busy hold-off and reset: i2c_busy=1 at grant -> new_dat is delayed until busy falls. Reset asserted in WAIT_DONE -> next cycle all outputs 0, no rsp_valid, next req is served from requester 0.
